mdu_sched: RTL

//  Sequencer for the iterative multiply (mul) and divide (div) units in the EX stage.
//  - Accepts M-extension ops from EX and latches their operands.
//  - Pulses start to the selected unit and stalls the pipeline until a result exists.
//  - Holds the result while MEM back-pressures.
//  - Caches the last quotient/remainder pair, so a DIV/REM pair on equal operands issues one division.

---
 rtl/mdu_sched_pkg.sv | 23 ++
 rtl/mdu_div_cache.sv | 59 +++++
 rtl/mdu_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared types and constants for the M-extension scheduler: FSM state
// encoding and the funct3 values/bit positions the scheduler cares about.
package mdu_sched_pkg;

    typedef enum logic [1:0] {
        MDU_ST_IDLE     = 2'd0,
        MDU_ST_MUL_BUSY = 2'd1,
        MDU_ST_DIV_BUSY = 2'd2,
        MDU_ST_HOLD     = 2'd3
    } mdu_state_e;

    // funct3 encodings of the M-extension ops driven by the bench and decoder
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // funct3[0] distinguishes signed/unsigned division, funct3[1] quotient/remainder
    localparam int F3_SIGN_BIT = 0;
    localparam int F3_REM_BIT  = 1;

endpackage

// File: rtl/mdu_div_cache.sv
// Remembers the operands, signedness and quotient/remainder of the last
// completed division so a DIV/REM pair on equal operands costs one division.
module mdu_div_cache
    import mdu_sched_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inval,
    input  logic [XLEN-1:0] load_op1,
    input  logic [XLEN-1:0] load_op2,
    input  logic            load_sign,
    input  logic [XLEN-1:0] load_quot,
    input  logic [XLEN-1:0] load_rem,
    input  logic [XLEN-1:0] query_op1,
    input  logic [XLEN-1:0] query_op2,
    input  logic            query_sign,
    input  logic            query_rem,
    output logic            hit,
    output logic [XLEN-1:0] word
);

    logic            vld;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic            sign_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;

    // Capture a finished division; an invalidate always takes precedence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= 1'b0;
            op1_q  <= '0;
            op2_q  <= '0;
            sign_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else if (inval) begin
            vld <= 1'b0;
        end else if (load) begin
            vld    <= 1'b1;
            op1_q  <= load_op1;
            op2_q  <= load_op2;
            sign_q <= load_sign;
            quot_q <= load_quot;
            rem_q  <= load_rem;
        end
    end

    // A hit needs identical operands and identical signedness; quotient vs remainder is free
    always_comb begin
        hit  = vld && (op1_q == query_op1) && (op2_q == query_op2) && (sign_q == query_sign);
        word = query_rem ? rem_q : quot_q;
    end

endmodule

// File: rtl/mdu_sched.sv
// EX-stage sequencer for the iterative multiply and divide units: latches
// operands, pulses start, stalls the pipe until a result exists, holds the
// result under MEM back-pressure and aborts stuck units with a watchdog.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_flush,
    input  logic            ex_valid,
    input  logic            ex_is_mul,
    input  logic            ex_is_div,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            mem_stall,
    output logic            mul_start,
    output logic            div_start,
    output logic            mdu_kill,
    output logic [XLEN-1:0] mdu_op1,
    output logic [XLEN-1:0] mdu_op2,
    output logic [2:0]      mdu_funct3,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_res,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem,
    output logic            mdu_stall,
    output logic [XLEN-1:0] mdu_res,
    output logic            mdu_res_vld,
    output logic            mdu_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    mdu_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [XLEN-1:0] res_q;
    logic            req;
    logic            cache_hit;
    logic [XLEN-1:0] cache_word;
    logic            cache_load;
    logic            cache_inval;

    // Request decode, pipeline stall and cache control; a flush suppresses any cache load
    always_comb begin
        req         = ex_valid && (ex_is_mul || ex_is_div) && !pipe_flush;
        mdu_stall   = req && !((state == MDU_ST_HOLD) && !mem_stall);
        cnt_inc     = cnt + CNT_W'(1);
        cache_load  = (state == MDU_ST_DIV_BUSY) && div_done && !pipe_flush;
        cache_inval = (state == MDU_ST_DIV_BUSY) && pipe_flush;
        mdu_res_vld = (state == MDU_ST_HOLD);
        mdu_res     = (state == MDU_ST_HOLD) ? res_q : '0;
    end

    mdu_div_cache #(
        .XLEN(XLEN)
    ) u_cache (
        .clk        (clk),
        .rst        (rst),
        .load       (cache_load),
        .inval      (cache_inval),
        .load_op1   (mdu_op1),
        .load_op2   (mdu_op2),
        .load_sign  (mdu_funct3[F3_SIGN_BIT]),
        .load_quot  (div_quot),
        .load_rem   (div_rem),
        .query_op1  (ex_rs1),
        .query_op2  (ex_rs2),
        .query_sign (ex_funct3[F3_SIGN_BIT]),
        .query_rem  (ex_funct3[F3_REM_BIT]),
        .hit        (cache_hit),
        .word       (cache_word)
    );

    // Scheduler FSM with watchdog; start/kill are one-cycle registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MDU_ST_IDLE;
            cnt         <= '0;
            res_q       <= '0;
            mul_start   <= 1'b0;
            div_start   <= 1'b0;
            mdu_kill    <= 1'b0;
            mdu_op1     <= '0;
            mdu_op2     <= '0;
            mdu_funct3  <= '0;
            mdu_timeout <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            mdu_kill  <= 1'b0;
            if (pipe_flush) begin
                if ((state == MDU_ST_MUL_BUSY) || (state == MDU_ST_DIV_BUSY)) begin
                    mdu_kill <= 1'b1;
                end
                res_q <= '0;
                state <= MDU_ST_IDLE;
            end else begin
                case (state)
                    MDU_ST_IDLE: begin
                        if (req) begin
                            if (ex_is_mul) begin
                                mdu_op1    <= ex_rs1;
                                mdu_op2    <= ex_rs2;
                                mdu_funct3 <= ex_funct3;
                                mul_start  <= 1'b1;
                                cnt        <= '0;
                                state      <= MDU_ST_MUL_BUSY;
                            end else if (cache_hit) begin
                                res_q <= cache_word;
                                state <= MDU_ST_HOLD;
                            end else begin
                                mdu_op1    <= ex_rs1;
                                mdu_op2    <= ex_rs2;
                                mdu_funct3 <= ex_funct3;
                                div_start  <= 1'b1;
                                cnt        <= '0;
                                state      <= MDU_ST_DIV_BUSY;
                            end
                        end
                    end
                    MDU_ST_MUL_BUSY, MDU_ST_DIV_BUSY: begin
                        if ((state == MDU_ST_MUL_BUSY) && mul_done) begin
                            res_q <= mul_res;
                            state <= MDU_ST_HOLD;
                        end else if ((state == MDU_ST_DIV_BUSY) && div_done) begin
                            res_q <= mdu_funct3[F3_REM_BIT] ? div_rem : div_quot;
                            state <= MDU_ST_HOLD;
                        end else if (cnt_inc == TIMEOUT_CNT) begin
                            mdu_kill    <= 1'b1;
                            mdu_timeout <= 1'b1;
                            res_q       <= '0;
                            state       <= MDU_ST_HOLD;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    MDU_ST_HOLD: begin
                        if (!mem_stall) begin
                            res_q <= '0;
                            state <= MDU_ST_IDLE;
                        end
                    end
                    default: state <= MDU_ST_IDLE;
                endcase
            end
        end
    end

endmodule
